motion_compensator: RTL and testbench
=====================================

// Module: motion_compensator
// PURPOSE
// - Decoder-side counterpart of the full-search motion estimator. It takes a motion vector and fetches the
//   matching 16x16 prediction block from the 32x32 search-window memory, raster order.
// - Adds a signed residual stream to each predicted pixel, saturates, and emits reconstructed pixels on a
//   valid/ready stream. Sits between search_memory and the frame write-back path.
// PARAMETERS
// - BLK      16  block edge in pixels (256 pixels per block)
// - WIN      32  search-window edge; memory address = row*WIN + col
// - ORG      8   window coordinate of the zero-vector block origin, same for x and y
// - PIX_W    8   pixel width, unsigned
// - RES_W    9   residual width, two's complement
// - MV_W     4   motion-vector component width, two's complement, range -8..+7
// PORTS
// - clk             in   1      rising-edge clock
// - rst             in   1      synchronous, active-high reset
// - start           in   1      single-cycle request; sampled only in IDLE
// - mv_x, mv_y      in   4      signed vector; sampled with start
// - busy            out  1      high from the cycle after an accepted start until done
// - done            out  1      one-cycle pulse after the last pixel handshake
// - address_search  out  10     search_memory read address (combinational read, same-cycle data)
// - search_data     in   8      search_memory read data
// - res_data        in   9      signed residual for the current pixel
// - res_valid       in   1      residual valid
// - res_ready       out  1      residual accepted when res_valid && res_ready
// - pix_data        out  8      reconstructed pixel, registered
// - pix_valid       out  1      pix_data valid
// - pix_ready       in   1      downstream accept
// - pix_last        out  1      qualifies the 256th pixel
// BEHAVIOUR
// - Reset values: busy=0, done=0, pix_valid=0, pix_last=0, pix_data=0, res_ready=0,
//   address_search=0, state=IDLE, idx=0.
// - FSM IDLE -> RUN on start. RUN -> FLUSH on the handshake with idx==255. FLUSH -> IDLE when the last
//   pixel is accepted (pix_valid && pix_ready && pix_last); done pulses in the first IDLE cycle.
// - start: latches mv_x/mv_y. base_x = ORG + mv_x and base_y = ORG + mv_y, both in the range 0..15,
//   so the block never leaves the window. start outside IDLE is ignored.
// - Address: address_search = (base_y + idx[7:4])*WIN + base_x + idx[3:0]. Maximum value is 990.
//   In IDLE/FLUSH it holds the last value.
// - Output register "slot" with one entry. In RUN, res_ready = !pix_valid || pix_ready.
//   On res handshake: pix_data <= clamp(search_data + res_data) computed at 10-bit signed width,
//   clamped to 0..255; pix_valid <= 1; pix_last <= (idx==255); idx++.
// - Else if pix_ready: pix_valid <= 0.
// - Latency: the pixel is on pix_data the cycle after its residual handshake. Throughput is one pixel/cycle
//   with res_valid and pix_ready held high. Block time is 256 cycles plus 1 drain cycle.
// - Stall: while pix_valid && !pix_ready, pix_data/pix_last are held stable and res_ready=0. No pixel is
//   dropped or duplicated.
// - res_valid low: idx and address hold. pix_valid drops after the current pixel is accepted.
// - idx wraps 255 -> 0 only via RUN -> FLUSH. It is never reused mid-block.
// - rst mid-block: next cycle all outputs take their reset values, the block is abandoned, and no done
//   pulse is produced.
// STRUCTURE
// - Shared package me_pkg:
//   - constants BLK_SIZE, WIN_SIZE, WIN_ORIGIN, PIX_W, RES_W, MV_W
//   - mc_state_t enum {IDLE, RUN, FLUSH}
//   - function sat_pix(signed [9:0]) -> [7:0]
// - One sub-module, mc_addr_gen: latches base_x/base_y on start and produces address_search from idx.
//   The FSM, output slot and saturation stay in the top module.
// TESTING
// - mv=(0,0), mem[a]=a[7:0], res=0, pix_ready=1: 256 pixels.
//   Pixel k = mem[(8+k/16)*32+8+k%16]; first=8 (addr 264), last addr 759. pix_last on #256; done one cycle later.
// - Extreme vectors:
//   - mv=(-8,-8): addresses 0..495.
//   - mv=(+7,+7): first 495, last 990; no address exceeds 990.
// - Saturation:
//   - pred 250, res +20 -> 255
//   - pred 5, res -20 -> 0
//   - pred 0, res +255 -> 255
//   - pred 255, res -256 -> 0
//   - pred 100, res -1 -> 99
// - Random pix_ready and res_valid gaps: output sequence equals the reference model exactly.
//   pix_data is stable during stalls; res_ready=0 whenever the slot is full and pix_ready=0.
// - start pulsed during RUN: ignored, mv unchanged.
//   rst at pixel 100: next cycle pix_valid=0, busy=0, done never pulses; a new start then restarts at pixel 0.
// - Back-to-back blocks: start asserted in the cycle done pulses; the second block begins with no
//   lost or stale pixel.

Source files
------------

// File: rtl/me_pkg.sv
// me_pkg: constants, the compensator state type and the pixel saturation
// helper shared by the motion-estimation and motion-compensation blocks.
package me_pkg;

  localparam int BLK_SIZE   = 16;  // block edge in pixels
  localparam int WIN_SIZE   = 32;  // search-window edge, address = row*WIN_SIZE + col
  localparam int WIN_ORIGIN = 8;   // window coordinate of the zero-vector block origin
  localparam int PIX_W      = 8;   // unsigned pixel width
  localparam int RES_W      = 9;   // two's complement residual width
  localparam int MV_W       = 4;   // two's complement motion-vector component width
  localparam int ADDR_W     = 10;  // search-window address width
  localparam int IDX_W      = 8;   // pixel index within a block (0..255)

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH
  } mc_state_t;

  // Clamp a 10-bit signed prediction+residual sum to the unsigned pixel range.
  function automatic logic [PIX_W-1:0] sat_pix(input logic signed [9:0] sum);
    if (sum < 10'sd0) begin
      return '0;
    end else if (sum > 10'sd255) begin
      return '1;
    end else begin
      return sum[PIX_W-1:0];
    end
  endfunction

endpackage

// File: rtl/mc_addr_gen.sv
// mc_addr_gen: latches the block base (WIN_ORIGIN + motion vector) when a
// block starts and keeps the search-window read address registered so that
// it always points at the pixel the top module is about to consume.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   load       accepted start: latch mv_x/mv_y, address -> block origin
//   mv_x, mv_y signed motion-vector components
//   advance    a residual was consumed and more pixels follow
//   idx_next   index of the next pixel to fetch
//   address    search-window read address
module mc_addr_gen
  import me_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [MV_W-1:0]   mv_x,
  input  logic [MV_W-1:0]   mv_y,
  input  logic              advance,
  input  logic [IDX_W-1:0]  idx_next,
  output logic [ADDR_W-1:0] address
);

  logic [4:0]        base_x_reg, base_y_reg;
  logic [4:0]        load_x, load_y;
  logic [ADDR_W-1:0] address_reg;

  // Sign-extend the vector; the 5-bit sum is always 0..15 for a -8..+7 vector.
  assign load_x = 5'(WIN_ORIGIN) + {mv_x[MV_W-1], mv_x};
  assign load_y = 5'(WIN_ORIGIN) + {mv_y[MV_W-1], mv_y};

  function automatic logic [ADDR_W-1:0] addr_of(input logic [4:0] bx, input logic [4:0] by,
                                                input logic [3:0] row, input logic [3:0] col);
    logic [ADDR_W-1:0] r;
    r = ADDR_W'(by) + ADDR_W'(row);
    return (r << 5) + ADDR_W'(bx) + ADDR_W'(col);
  endfunction

  // The address only moves on load/advance, so it holds its last value
  // through FLUSH and IDLE even though idx wraps to 0 at the block end.
  always_ff @(posedge clk) begin
    if (rst) begin
      base_x_reg  <= '0;
      base_y_reg  <= '0;
      address_reg <= '0;
    end else if (load) begin
      base_x_reg  <= load_x;
      base_y_reg  <= load_y;
      address_reg <= addr_of(load_x, load_y, 4'd0, 4'd0);
    end else if (advance) begin
      address_reg <= addr_of(base_x_reg, base_y_reg, idx_next[7:4], idx_next[3:0]);
    end
  end

  assign address = address_reg;

endmodule

// File: rtl/motion_compensator.sv
// motion_compensator: fetches the 16x16 prediction block selected by a motion
// vector from the 32x32 search window, adds a signed residual per pixel,
// saturates, and streams the reconstructed pixels out in raster order.
// Ports:
//   clk, rst                clock, synchronous active-high reset
//   start, mv_x, mv_y       block request and its vector (sampled in IDLE)
//   busy, done              block in progress / one-cycle completion pulse
//   address_search          search_memory address (data returns same cycle)
//   search_data             predicted pixel
//   res_data/valid/ready    signed residual stream in
//   pix_data/valid/ready    reconstructed pixel stream out
//   pix_last                marks the 256th pixel of the block
module motion_compensator
  import me_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [MV_W-1:0]   mv_x,
  input  logic [MV_W-1:0]   mv_y,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] address_search,
  input  logic [PIX_W-1:0]  search_data,
  input  logic [RES_W-1:0]  res_data,
  input  logic              res_valid,
  output logic              res_ready,
  output logic [PIX_W-1:0]  pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_last
);

  mc_state_t         state_reg, state_next;
  logic [IDX_W-1:0]  idx_reg;
  logic [PIX_W-1:0]  pix_data_reg;
  logic              pix_valid_reg, pix_last_reg, done_reg;
  logic              load, res_hs, last_accept, idx_at_end;
  logic signed [9:0] sum;

  assign load        = start && (state_reg == IDLE);
  // The single-entry output slot can take a new pixel when empty or draining.
  assign res_ready   = (state_reg == RUN) && (!pix_valid_reg || pix_ready);
  assign res_hs      = res_valid && res_ready;
  assign idx_at_end  = (idx_reg == 8'd255);
  assign last_accept = pix_valid_reg && pix_ready && pix_last_reg;
  assign sum         = $signed({2'b00, search_data}) + $signed({res_data[RES_W-1], res_data});

  mc_addr_gen u_addr_gen (
    .clk      (clk),
    .rst      (rst),
    .load     (load),
    .mv_x     (mv_x),
    .mv_y     (mv_y),
    .advance  (res_hs && !idx_at_end),
    .idx_next (idx_reg + 8'd1),
    .address  (address_search)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    busy       = (state_reg != IDLE);
    case (state_reg)
      IDLE:    if (start) state_next = RUN;
      RUN:     if (res_hs && idx_at_end) state_next = FLUSH;
      FLUSH:   if (last_accept) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      idx_reg       <= '0;
      pix_data_reg  <= '0;
      pix_valid_reg <= 1'b0;
      pix_last_reg  <= 1'b0;
      done_reg      <= 1'b0;
    end else begin
      done_reg <= (state_reg == FLUSH) && last_accept;
      if (load) begin
        idx_reg <= '0;
      end else if (res_hs) begin
        idx_reg <= idx_reg + 8'd1;  // wraps to 0 exactly as the block completes
      end
      if (res_hs) begin
        pix_data_reg  <= sat_pix(sum);
        pix_valid_reg <= 1'b1;
        pix_last_reg  <= idx_at_end;
      end else if (pix_ready) begin
        pix_valid_reg <= 1'b0;
        pix_last_reg  <= 1'b0;
      end
    end
  end

  assign done      = done_reg;
  assign pix_data  = pix_data_reg;
  assign pix_valid = pix_valid_reg;
  assign pix_last  = pix_last_reg;

endmodule

// File: tb/tb_motion_compensator.sv
// tb_motion_compensator: directed checks of the motion compensator against a
// search-window memory model and an independent reconstruction model.
module tb_motion_compensator;

  logic       clk, rst, start;
  logic [3:0] mv_x, mv_y;
  logic       busy, done;
  logic [9:0] address_search;
  logic [7:0] search_data;
  logic [8:0] res_data;
  logic       res_valid, res_ready;
  logic [7:0] pix_data;
  logic       pix_valid, pix_ready, pix_last;

  logic [7:0] mem [1024];
  int         res_vec [256];
  int         exp_pix [256];
  int         got_pix [256];
  int         checks = 0;
  int         failures = 0;

  motion_compensator dut (
    .clk            (clk),
    .rst            (rst),
    .start          (start),
    .mv_x           (mv_x),
    .mv_y           (mv_y),
    .busy           (busy),
    .done           (done),
    .address_search (address_search),
    .search_data    (search_data),
    .res_data       (res_data),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .pix_data       (pix_data),
    .pix_valid      (pix_valid),
    .pix_ready      (pix_ready),
    .pix_last       (pix_last)
  );

  assign search_data = mem[address_search];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int sat_ref(input int p, input int r);
    int s;
    s = p + r;
    if (s < 0) return 0;
    if (s > 255) return 255;
    return s;
  endfunction

  function automatic int addr_ref(input int mvx, input int mvy, input int k);
    return (8 + mvy + k / 16) * 32 + 8 + mvx + k % 16;
  endfunction

  // Runs one block; start is raised in whatever cycle the call happens, so
  // calling it right after a previous block gives back-to-back operation.
  task automatic run_block(input int mvx, input int mvy, input bit gaps,
                           input int first_addr, input int glitch_at);
    int sent, got_n, cyc, tmp, gx;
    bit rh, ph, prev_stall, prev_last;
    logic [7:0] cur_data, prev_data;
    logic cur_last;
    for (int k = 0; k < 256; k++) exp_pix[k] = sat_ref(int'(mem[addr_ref(mvx, mvy, k)]), res_vec[k]);
    start = 1'b1;
    mv_x = mvx[3:0];
    mv_y = mvy[3:0];
    @(posedge clk); #1;
    start = 1'b0;
    check("busy_after_start", busy, 1);
    check("first_addr", address_search, first_addr);
    sent = 0; got_n = 0; cyc = 0; prev_stall = 0; prev_data = '0; prev_last = 0;
    while (got_n < 256 && cyc < 4000) begin
      res_valid = gaps ? ($urandom_range(3) != 0) : 1'b1;
      pix_ready = gaps ? ($urandom_range(3) != 0) : 1'b1;
      tmp = (sent < 256) ? res_vec[sent] : 0;
      res_data = tmp[8:0];
      if (cyc == glitch_at) begin
        gx = mvx - 3;
        start = 1'b1;
        mv_x = gx[3:0];
        mv_y = gx[3:0];
      end else begin
        start = 1'b0;
      end
      #1;
      if (sent < 256) check("addr", address_search, addr_ref(mvx, mvy, sent));
      if (pix_valid && !pix_ready) check("res_ready_stall", res_ready, 0);
      if (prev_stall) begin
        check("stall_valid", pix_valid, 1);
        check("stall_data", pix_data, prev_data);
        check("stall_last", pix_last, prev_last);
      end
      rh = res_valid && res_ready;
      ph = pix_valid && pix_ready;
      cur_data = pix_data;
      cur_last = pix_last;
      prev_stall = pix_valid && !pix_ready;
      prev_data = pix_data;
      prev_last = pix_last;
      @(posedge clk); #1;
      cyc++;
      if (ph) begin
        got_pix[got_n] = cur_data;
        check("pix", cur_data, exp_pix[got_n]);
        check("pix_last", cur_last, got_n == 255);
        got_n++;
      end
      if (ph && !rh) check("valid_drop", pix_valid, 0);
      if (rh) sent++;
    end
    start = 1'b0;
    check("block_in_budget", got_n, 256);
    check("done_pulse", done, 1);
    check("busy_end", busy, 0);
    if (!gaps) check("block_cycles", cyc, 257);
    $display("block mv=(%0d,%0d) gaps=%0d pixels=%0d cycles=%0d", mvx, mvy, gaps, got_n, cyc);
  endtask

  initial begin
    int r;
    rst = 1'b1; start = 1'b0; mv_x = '0; mv_y = '0;
    res_data = '0; res_valid = 1'b0; pix_ready = 1'b0;
    for (int a = 0; a < 1024; a++) mem[a] = a[7:0];
    for (int k = 0; k < 256; k++) res_vec[k] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_pix_valid", pix_valid, 0);
    check("rst_pix_last", pix_last, 0);
    check("rst_pix_data", pix_data, 0);
    check("rst_res_ready", res_ready, 0);
    check("rst_addr", address_search, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Zero vector, identity memory, zero residual.
    run_block(0, 0, 1'b0, 264, -1);
    check("t1_first_pix", got_pix[0], 8);
    check("t1_last_pix", got_pix[255], 247);
    // Extreme vectors, each started in the cycle the previous done pulses.
    run_block(-8, -8, 1'b0, 0, -1);
    check("mvmin_last_addr", address_search, 495);
    run_block(7, 7, 1'b0, 495, -1);
    check("mvmax_last_addr", address_search, 990);
    @(posedge clk); #1;
    check("done_one_cycle", done, 0);

    // Saturation corners in the first five pixels.
    mem[264] = 8'd250; res_vec[0] = 20;
    mem[265] = 8'd5;   res_vec[1] = -20;
    mem[266] = 8'd0;   res_vec[2] = 255;
    mem[267] = 8'd255; res_vec[3] = -256;
    mem[268] = 8'd100; res_vec[4] = -1;
    run_block(0, 0, 1'b0, 264, -1);
    check("sat_250_p20", got_pix[0], 255);
    check("sat_5_m20", got_pix[1], 0);
    check("sat_0_p255", got_pix[2], 255);
    check("sat_255_m256", got_pix[3], 0);
    check("sat_100_m1", got_pix[4], 99);

    // Random data with stalls and residual gaps; start glitch during RUN.
    for (int a = 0; a < 1024; a++) begin
      r = $urandom_range(255);
      mem[a] = r[7:0];
    end
    for (int k = 0; k < 256; k++) res_vec[k] = $urandom_range(511) - 256;
    run_block(3, -5, 1'b1, 3 * 32 + 11, 30);

    // Reset in the middle of a block.
    for (int k = 0; k < 256; k++) res_vec[k] = 0;
    @(posedge clk); #1;
    res_valid = 1'b1; pix_ready = 1'b1;
    start = 1'b1; mv_x = 4'd2; mv_y = 4'd1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (100) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_pix_valid", pix_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_res_ready", res_ready, 0);
    check("midrst_addr", address_search, 0);
    for (int c = 0; c < 20; c++) begin
      check("midrst_no_done", done, 0);
      @(posedge clk); #1;
    end
    run_block(0, 0, 1'b0, 264, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
